// File: rtl/ad9643_spi_master.sv
// SPI master for the AD9643 3-wire register port: one 24-bit instruction+data frame per request.
// The frame is MSB first, uses mode 0 with sclk idling low, and hands SDIO to the slave for the data byte of reads.
module ad9643_spi_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CSS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [12:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        busy,
    output logic        sclk,
    output logic        ss_n,
    output logic        sdio_o,
    input  logic        sdio_i,
    output logic        sdio_t
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FRAME_W = 24;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CSS_LAST = CNT_W'(CSS_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_TURN = BIT_W'(15);
    localparam logic [BIT_W-1:0] BIT_DATA = BIT_W'(16);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]    rx_q, rx_d;
    logic                 rw_q, rw_d;
    logic                 sclk_q, sclk_d;
    logic                 ss_n_q, ss_n_d;
    logic                 sdio_o_q, sdio_o_d;
    logic                 sdio_t_q, sdio_t_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]    resp_rdata_q, resp_rdata_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        rw_d         = rw_q;
        sclk_d       = sclk_q;
        ss_n_d       = ss_n_q;
        sdio_o_d     = sdio_o_q;
        sdio_t_d     = sdio_t_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d  = SETUP;
                    cnt_d    = '0;
                    bit_d    = '0;
                    rw_d     = req_rw;
                    tx_d     = {req_rw, 2'b00, req_addr, req_rw ? 8'h00 : req_wdata};
                    ss_n_d   = 1'b0;
                    sdio_t_d = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == CSS_LAST) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    sdio_o_d = tx_q[FRAME_W-1];
                    tx_d     = {tx_q[FRAME_W-2:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // Capture on the first cycle sclk reads high during the read data byte
                if (sclk_q && (cnt_q == '0) && rw_q && (bit_q >= BIT_DATA)) begin
                    rx_d = {rx_q[DATA_W-2:0], sdio_i};
                end
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                        end else begin
                            bit_d    = bit_q + BIT_W'(1);
                            sdio_o_d = tx_q[FRAME_W-1];
                            tx_d     = {tx_q[FRAME_W-2:0], 1'b0};
                            if (rw_q && (bit_q == BIT_TURN)) begin
                                sdio_t_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CSS_LAST) begin
                    state_d      = GAP;
                    cnt_d        = '0;
                    ss_n_d       = 1'b1;
                    sdio_t_d     = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rw_q ? rx_q : 8'h00;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CSS_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            rw_q         <= 1'b0;
            sclk_q       <= 1'b0;
            ss_n_q       <= 1'b1;
            sdio_o_q     <= 1'b0;
            sdio_t_q     <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            rw_q         <= rw_d;
            sclk_q       <= sclk_d;
            ss_n_q       <= ss_n_d;
            sdio_o_q     <= sdio_o_d;
            sdio_t_q     <= sdio_t_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign sclk       = sclk_q;
    assign ss_n       = ss_n_q;
    assign sdio_o     = sdio_o_q;
    assign sdio_t     = sdio_t_q;

endmodule

// File: doc/ad9643_spi_master.md
AD9643_SPI_MASTER -- requirements
Module: ad9643_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CSS_CYCLES, default 2: SS_N setup, hold and minimum inter-frame gap in clk cycles; legal range 1..15.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  host request strobe.
REQ-006 req_ready  output  1  block SHALL accept a request when req_valid and req_ready are both high.
REQ-007 req_rw  input  1  1 = read, 0 = write; sampled at accept.
REQ-008 req_addr  input  13  register address A12..A0; sampled at accept.
REQ-009 req_wdata  input  8  write data; sampled at accept and ignored for reads.
REQ-010 resp_valid  output  1  one-cycle pulse marking end of frame.
REQ-011 resp_rdata  output  8  read data; valid while resp_valid is high; 0x00 for writes.
REQ-012 busy  output  1  high from accept until req_ready returns high.
REQ-013 sclk  output  1  SPI clock to the ADC SPI slave; idles low (mode 0).
REQ-014 ss_n  output  1  SPI chip select, active low.
REQ-015 sdio_o  output  1  serial data driven toward SDIO.
REQ-016 sdio_i  input  1  serial data received from SDIO.
REQ-017 sdio_t  output  1  IOBUF tristate control: 1 = master releases SDIO (input), 0 = master drives.

Function
REQ-018 Frame SHALL be 24 bits, MSB first: bit0 = R/W, bits1-2 = W1:W0 = 00, bits3-15 = A12..A0, bits16-23 = D7..D0.
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-020 req_ready SHALL be high only in IDLE.
REQ-021 At accept cycle T, the FSM SHALL latch the request and enter SETUP; ss_n SHALL go low at T+1.
REQ-022 SETUP SHALL last CSS_CYCLES cycles with sclk low, then the FSM SHALL enter SHIFT.
REQ-023 Each SHIFT bit SHALL be CLK_DIV cycles with sclk low followed by CLK_DIV cycles with sclk high.
REQ-024 sdio_o SHALL update only at the start of a low phase.
REQ-025 The slave samples sdio_o on sclk rising edges.
REQ-026 On the clk cycle in which sclk first reads high for bits 16-23 of a read, the master SHALL shift sdio_i into the read shift register.
REQ-027 Writes SHALL hold sdio_t = 0 for all 24 bits.
REQ-028 Reads SHALL hold sdio_t = 0 for bits 0-15 and set sdio_t = 1 at the start of the bit-16 low phase (the falling edge after the 16th rising edge).
REQ-029 After the bit-23 high phase, sclk SHALL return low and the FSM SHALL enter HOLD for CSS_CYCLES cycles with ss_n still low.
REQ-030 On HOLD exit, ss_n SHALL go high, sdio_t SHALL go to 1, and resp_valid SHALL pulse for one cycle at T+1+2*CSS_CYCLES+48*CLK_DIV.
REQ-031 After HOLD, GAP SHALL last CSS_CYCLES cycles, then the FSM SHALL return to IDLE with req_ready high.
REQ-032 Bit counter SHALL be 5 bits counting 0..23 with no wrap beyond 23.
REQ-033 Phase counter SHALL count 0..CLK_DIV-1 and reload at each sclk toggle.
REQ-034 req_valid asserted outside IDLE SHALL be ignored, with no latching and no effect on the frame in flight.
REQ-035 The request inputs may change freely after accept without affecting the frame.
REQ-036 resp_rdata SHALL hold its value until the next resp_valid.
REQ-037 sclk, ss_n, sdio_o and sdio_t SHALL be driven directly from flip-flops (glitch-free).

Reset
REQ-038 While reset is high, the FSM SHALL go to IDLE and outputs SHALL be: sclk = 0, ss_n = 1, sdio_o = 0, sdio_t = 1, resp_valid = 0, resp_rdata = 0x00, busy = 0, req_ready = 0.
REQ-039 req_ready SHALL rise on the first cycle after reset deasserts.
REQ-040 Reset asserted mid-frame SHALL abort the frame on the next clk edge with ss_n = 1, sclk = 0 and no resp_valid.
REQ-041 After a mid-frame reset, the next request SHALL start a complete new frame.

Verification
REQ-042 Write, CLK_DIV=4, CSS=2, addr 0x00B, data 0x03 -> slave model captures 0x000B03 over 24 rising edges; sdio_t = 0 throughout; resp_valid at T+197; resp_rdata = 0x00.
REQ-043 Read, addr 0x001, slave model drives 0x82 -> instruction captured as 0x8001; sdio_t rises after the 16th rising edge; resp_rdata = 0x82.
REQ-044 Back-to-back write then read, req_valid held high -> second accept occurs exactly CSS_CYCLES cycles after the first resp_valid; ss_n high for at least 2 cycles between frames.
REQ-045 req_valid pulsed with addr 0x1FFF during SHIFT of a write to 0x014 -> only the 0x014 frame is seen; no second frame occurs.
REQ-046 Reset asserted at bit 10 -> next cycle ss_n = 1, sclk = 0, sdio_t = 1, no resp_valid; a following write of 0x05 to 0x0FF completes correctly.
REQ-047 CLK_DIV=1, read of 0x000 returning 0xA5 -> sclk period is 2 clk cycles; resp_rdata = 0xA5 at T+53.
